// File: rtl/tas_ctrl_pkg.sv
// Shared types and constants for the TAS replay latch/frame scheduler.
package tas_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } sched_state_t;

  localparam int unsigned SYNC_STAGES       = 2;
  localparam int unsigned LOAD_PULSE_CYCLES = 2;
  localparam int unsigned COUNT_W           = 16;

  // Saturating increment for the event counters.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    sat_inc = (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Power-of-two frame FIFO: registered pointers and level, head visible combinationally.
module frame_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push_ok_c = push_i && !full_o;
  assign pop_ok_c  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok_c && !pop_ok_c)      level_d = level_q + LW'(1);
    else if (pop_ok_c && !push_ok_c) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; pointer reset discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/latch_frame_scheduler.sv
// Console latch/clock synchronizer and frame sequencer feeding one shift register
// during TAS replay, with multi-latch windowing and overread/underrun accounting.
module latch_frame_scheduler
  import tas_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned WINDOW_CYCLES = 2000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           frame_in,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  input  logic                       console_latch,
  input  logic                       console_clk,
  output logic [WIDTH-1:0]           frame_out,
  output logic                       load_out,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [6:0]                 bit_count,
  output logic [COUNT_W-1:0]         overread_count,
  output logic [COUNT_W-1:0]         underrun_count
);

  localparam int unsigned WIN_W  = (WINDOW_CYCLES > 0) ? $clog2(WINDOW_CYCLES + 1) : 1;
  localparam int unsigned BITC_W = 7;
  localparam int unsigned PCNT_W = (LOAD_PULSE_CYCLES > 1) ? $clog2(LOAD_PULSE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] cclk_sync_q;
  logic                   latch_prev_q;
  logic                   cclk_prev_q;
  logic                   latch_rise_c;
  logic                   clk_edge_c;

  sched_state_t           state_q, state_d;
  logic [PCNT_W-1:0]      pulse_cnt_q, pulse_cnt_d;
  logic                   load_q, load_d;
  logic                   count_clk_c;

  logic [WIN_W-1:0]       win_q;
  logic [WIDTH-1:0]       frame_q;
  logic [BITC_W-1:0]      bit_cnt_q;
  logic [COUNT_W-1:0]     overread_q;
  logic [COUNT_W-1:0]     underrun_q;

  logic                   consume_c;
  logic                   pop_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WIDTH-1:0]       fifo_head;

  frame_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (frame_valid),
    .data_i  (frame_in),
    .pop_i   (pop_c),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Two-flop synchronizers plus a third flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync_q <= '0;
      cclk_sync_q  <= '0;
      latch_prev_q <= 1'b0;
      cclk_prev_q  <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], console_latch};
      cclk_sync_q  <= {cclk_sync_q[SYNC_STAGES-2:0], console_clk};
      latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
      cclk_prev_q  <= cclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign latch_rise_c = latch_sync_q[SYNC_STAGES-1] && !latch_prev_q;
  assign clk_edge_c   = cclk_sync_q[SYNC_STAGES-1] && !cclk_prev_q && !latch_rise_c;

  // A push landing in the same cycle is not yet visible to this pop.
  assign consume_c = latch_rise_c && enable && (win_q == '0);
  assign pop_c     = consume_c && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    if (latch_rise_c) begin
      state_d     = LOAD;
      pulse_cnt_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (pulse_cnt_q == PCNT_W'(LOAD_PULSE_CYCLES - 1)) state_d = SHIFT;
          else pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
        end
        SHIFT:   state_d = SHIFT;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load_d      = (state_d == LOAD);
    count_clk_c = (state_q == SHIFT) && clk_edge_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q     <= 1'b0;
      frame_q    <= '1;
      win_q      <= '0;
      bit_cnt_q  <= '0;
      overread_q <= '0;
      underrun_q <= '0;
    end else begin
      load_q <= load_d;

      if (!enable)    frame_q <= '1;
      else if (pop_c) frame_q <= fifo_head;

      if (!enable)            win_q <= '0;
      else if (consume_c)     win_q <= WIN_W'(WINDOW_CYCLES);
      else if (win_q != '0)   win_q <= win_q - WIN_W'(1);

      if (latch_rise_c)
        bit_cnt_q <= '0;
      else if (count_clk_c && bit_cnt_q != {BITC_W{1'b1}})
        bit_cnt_q <= bit_cnt_q + BITC_W'(1);

      if (count_clk_c && (32'(bit_cnt_q) >= 32'(WIDTH)))
        overread_q <= sat_inc(overread_q);

      if (consume_c && fifo_empty)
        underrun_q <= sat_inc(underrun_q);
    end
  end

  assign frame_ready    = !fifo_full;
  assign frame_out      = frame_q;
  assign load_out       = load_q;
  assign bit_count      = bit_cnt_q;
  assign overread_count = overread_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_latch_frame_scheduler.sv
// Directed self-checking bench for latch_frame_scheduler (WIDTH=16, DEPTH=8, WINDOW_CYCLES=100).
module tb_latch_frame_scheduler;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [WIDTH-1:0]  frame_in;
  logic              frame_valid;
  logic              frame_ready;
  logic              console_latch;
  logic              console_clk;
  logic [WIDTH-1:0]  frame_out;
  logic              load_out;
  logic [3:0]        fifo_level;
  logic [6:0]        bit_count;
  logic [15:0]       overread_count;
  logic [15:0]       underrun_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic             ld_pre, ld1, ld2, ld_post;
  logic [WIDTH-1:0] fo_at_load;
  logic [6:0]       bc_at_load;

  latch_frame_scheduler #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .WINDOW_CYCLES (100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .frame_in       (frame_in),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .console_latch  (console_latch),
    .console_clk    (console_clk),
    .frame_out      (frame_out),
    .load_out       (load_out),
    .fifo_level     (fifo_level),
    .bit_count      (bit_count),
    .overread_count (overread_count),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
  endtask

  task automatic push_one(input logic [WIDTH-1:0] d);
    frame_valid = 1'b1;
    frame_in    = d;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic push_n(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      frame_valid = 1'b1;
      frame_in    = base + WIDTH'(i);
      @(negedge clk);
    end
    frame_valid = 1'b0;
  endtask

  // Latch rise at the current negedge; load_out is expected high on the 3rd and 4th negedges.
  task automatic latch_seq(input bit do_push, input logic [WIDTH-1:0] d);
    console_latch = 1'b1;
    wait_neg(2);
    ld_pre = load_out;
    if (do_push) begin
      frame_valid = 1'b1;
      frame_in    = d;
    end
    @(negedge clk);
    frame_valid = 1'b0;
    ld1        = load_out;
    fo_at_load = frame_out;
    bc_at_load = bit_count;
    @(negedge clk);
    ld2 = load_out;
    @(negedge clk);
    ld_post = load_out;
    console_latch = 1'b0;
    wait_neg(2);
  endtask

  task automatic clk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      console_clk = 1'b1;
      wait_neg(4);
      console_clk = 1'b0;
      wait_neg(4);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b1;
    frame_in      = '0;
    frame_valid   = 1'b0;
    console_latch = 1'b0;
    console_clk   = 1'b0;
    wait_neg(3);

    check("rst_frame_out", 32'(frame_out), 32'hFFFF);
    check("rst_load_out", 32'(load_out), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(frame_ready), 32'd1);
    check("rst_counters", 32'({bit_count, overread_count, underrun_count} != '0), 32'd0);
    rst_n = 1'b1;
    wait_neg(1);

    push_one(16'h1234);
    push_one(16'hABCD);
    check("push_level", 32'(fifo_level), 32'd2);

    latch_seq(1'b0, '0);
    check("l1_load_pre", 32'(ld_pre), 32'd0);
    check("l1_load_c1", 32'(ld1), 32'd1);
    check("l1_load_c2", 32'(ld2), 32'd1);
    check("l1_load_post", 32'(ld_post), 32'd0);
    check("l1_frame", 32'(fo_at_load), 32'h1234);
    check("l1_level", 32'(fifo_level), 32'd1);

    wait_neg(43);
    latch_seq(1'b0, '0);
    check("win_load", 32'(ld1), 32'd1);
    check("win_frame", 32'(fo_at_load), 32'h1234);
    check("win_level", 32'(fifo_level), 32'd1);

    wait_neg(100);
    latch_seq(1'b0, '0);
    check("l3_frame", 32'(fo_at_load), 32'hABCD);
    check("l3_level", 32'(fifo_level), 32'd0);
    check("l3_underrun", 32'(underrun_count), 32'd0);

    do_reset();
    latch_seq(1'b0, '0);
    check("ur_frame", 32'(fo_at_load), 32'hFFFF);
    check("ur_count", 32'(underrun_count), 32'd1);
    check("ur_level", 32'(fifo_level), 32'd0);

    clk_pulses(20);
    check("bits_20", 32'(bit_count), 32'd20);
    check("overread_4", 32'(overread_count), 32'd4);
    latch_seq(1'b0, '0);
    check("bits_cleared", 32'(bc_at_load), 32'd0);
    check("ur_count2", 32'(underrun_count), 32'd2);
    check("overread_hold", 32'(overread_count), 32'd4);

    wait_neg(100);
    latch_seq(1'b1, 16'h5555);
    check("pe_frame", 32'(fo_at_load), 32'hFFFF);
    check("pe_underrun", 32'(underrun_count), 32'd3);
    check("pe_level", 32'(fifo_level), 32'd1);

    do_reset();
    push_n(16'h1000, 8);
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_ready", 32'(frame_ready), 32'd0);
    push_one(16'hDEAD);
    check("full_push_ignored", 32'(fifo_level), 32'd8);

    do_reset();
    push_n(16'h2000, 4);
    latch_seq(1'b1, 16'h2004);
    check("pp_frame", 32'(fo_at_load), 32'h2000);
    check("pp_level", 32'(fifo_level), 32'd4);

    do_reset();
    push_n(16'h3000, 4);
    latch_seq(1'b0, '0);
    check("en_pop_frame", 32'(fo_at_load), 32'h3000);
    enable = 1'b0;
    wait_neg(2);
    check("dis_frame_idle", 32'(frame_out), 32'hFFFF);
    console_latch = 1'b1;
    wait_neg(3);
    check("dis_load", 32'(load_out), 32'd1);
    check("dis_frame", 32'(frame_out), 32'hFFFF);
    check("dis_level", 32'(fifo_level), 32'd3);
    check("dis_underrun", 32'(underrun_count), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_load", 32'(load_out), 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    console_latch = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_frame_scheduler.md
Name: latch_frame_scheduler

Overview:
Sequences the console-facing shift registers during TAS replay. Buffers host-supplied controller frames in a small FIFO and synchronizes the console latch and clock lines into the system clock domain. On each qualifying latch it pops one frame, presents it on frame_out and pulses load_out; it also tracks bits clocked out, overreads and underruns. It sits between the host/USB frame source and one shift_register_N instance with matching WIDTH.

Parameters:
WIDTH, 16, frame width in bits (8/16/32/64), equal to the driven shift register's width
DEPTH, 8, frame FIFO entries (power of two, >=2)
WINDOW_CYCLES, 2000, clk cycles after a frame-consuming latch during which further latches reuse the same frame (multi-latch games); 0 disables windowing

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  replay enable; when low no pops occur and frame_out is forced idle
frame_in  in  WIDTH  host frame data
frame_valid  in  1  host frame strobe
frame_ready  out  1  FIFO not full
console_latch  in  1  raw console latch (asynchronous)
console_clk  in  1  raw console data clock (asynchronous)
frame_out  out  WIDTH  frame presented to shift register next_frame
load_out  out  1  drives shift register load
fifo_level  out  $clog2(DEPTH)+1  entries held
bit_count  out  7  console clocks since last latch, saturating at 127
overread_count  out  16  clocks beyond WIDTH, saturating
underrun_count  out  16  consuming latches with empty FIFO, saturating

Behaviour:
- Reset: frame_out all ones; load_out 0; FIFO empty; fifo_level 0; frame_ready 1; all counters 0; window timer 0; state IDLE.
- Sync: console_latch and console_clk each pass through 2 flops. A rising edge is detected against a 3rd flop. Latency from raw edge to edge pulse is 3 clk.
- Push: when frame_valid && frame_ready, write frame_in. A push while full is impossible (ready low) and is ignored if forced.
- States:
  - IDLE: waits for latch edge.
  - LOAD: load_out=1 for exactly 2 cycles.
  - SHIFT: counts clocks.
- Transitions: latch edge from any state -> LOAD, restarting the 2-cycle pulse; after 2 cycles -> SHIFT; SHIFT stays until the next latch edge.
- Latch edge with enable=1 and window timer==0 (consuming latch):
  - FIFO non-empty: pop, frame_out <= head next cycle.
  - FIFO empty: frame_out unchanged (repeat last frame), underrun_count++.
  - In both cases the window timer loads WINDOW_CYCLES.
- Latch edge with window timer>0: no pop, frame_out unchanged, load still pulsed, timer not reloaded.
- Window timer decrements by 1 each cycle to 0.
- frame_out is updated on the cycle load_out rises, so data is stable for the whole pulse.
- Latch edge clears bit_count. Each console_clk edge in SHIFT increments bit_count. If bit_count >= WIDTH at that edge, overread_count++.
- console_clk edge and latch edge in the same cycle: the latch wins and the clock edge is dropped.
- Simultaneous push and pop: both occur and fifo_level is unchanged. A push into an empty FIFO in the same cycle as a consuming latch is not visible to that pop: underrun is counted and the entry remains.
- enable=0:
  - frame_out forced all ones.
  - Latches still pulse load_out but never pop or count underruns.
  - Window timer held at 0.
  - Pushes still accepted.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- rst_n low mid-pulse: load_out drops immediately and the FIFO contents are discarded.

Decomposition:
- Package tas_ctrl_pkg holds:
  - sched_state_t enum {IDLE, LOAD, SHIFT}
  - SYNC_STAGES=2
  - LOAD_PULSE_CYCLES=2
  - COUNT_W=16 (counter width)
- Sub-module frame_fifo (WIDTH, DEPTH; push/pop/level, async active-low reset) holds storage and pointers. The scheduler keeps the sync, FSM, window timer and counters.

Test Plan:
- Reset, push 0x1234 and 0xABCD (WIDTH=16), latch -> load_out high 2 cycles starting 3-4 clk after latch; frame_out=0x1234; fifo_level 2->1.
- WINDOW_CYCLES=100, two latches 50 cycles apart with 2 frames queued -> both loads show the same frame; fifo_level drops by 1; second latch after 150 cycles pops the next frame.
- Empty FIFO, latch -> frame_out keeps previous value (0xFFFF after reset); underrun_count=1; level stays 0.
- Latch then 20 console_clk pulses, WIDTH=16 -> bit_count=20, overread_count=4; next latch clears bit_count to 0.
- Fill DEPTH=8 -> frame_ready=0 and a 9th push is ignored; push and consuming latch in the same cycle at level 8 is impossible, so test at level 4 -> level stays 4.
- enable=0 with 3 frames queued, latch -> frame_out=all ones, load pulses, level stays 3; assert rst_n mid-LOAD -> load_out=0 immediately and level=0.
